// File: rtl/lift_pkg.sv
// Shared state encoding and direction constants for the lift controller.
package lift_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MOVE_UP = 2'd1,
    ST_MOVE_DN = 2'd2,
    ST_DOOR    = 2'd3
  } state_e;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

endpackage

// File: rtl/lift_timer.sv
// Loadable down-counter shared by travel and door dwell timing.
// Saturates at zero; expired is high while the count is zero.
module lift_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expired
);

  logic [W-1:0] count_r;

  // Count register: load wins, otherwise count down to zero and hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= {W{1'b0}};
    end else if (load) begin
      count_r <= load_val;
    end else if (count_r != {W{1'b0}}) begin
      count_r <= count_r - {{(W-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign expired = (count_r == {W{1'b0}});

endmodule

// File: rtl/lift_ctrl.sv
// Single-car collective (SCAN) elevator controller with timed travel and
// door dwell. All outputs come straight from registers.
module lift_ctrl
  import lift_pkg::*;
#(
  parameter int FLOORS   = 8,
  parameter int FLOOR_W  = $clog2(FLOORS),
  parameter int MOVE_CYC = 4,
  parameter int DOOR_CYC = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [FLOORS-1:0]  hall_req,
  input  logic [FLOORS-1:0]  car_req,
  input  logic               door_hold,
  output logic [FLOOR_W-1:0] floor_o,
  output logic               dir_up_o,
  output logic               moving_o,
  output logic               door_open_o,
  output logic               busy_o,
  output logic [FLOORS-1:0]  pending_o
);

  localparam int TMAX = (MOVE_CYC > DOOR_CYC) ? MOVE_CYC : DOOR_CYC;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam logic [TW-1:0]     MOVE_LD = TW'(MOVE_CYC - 1);
  localparam logic [TW-1:0]     DOOR_LD = TW'(DOOR_CYC - 1);
  localparam logic [FLOORS-1:0] ONE     = {{(FLOORS-1){1'b0}}, 1'b1};

  state_e              state_r, state_nxt_s;
  logic [FLOOR_W-1:0]  floor_r, floor_nxt_s;
  logic                dir_r, dir_nxt_s;
  logic [FLOORS-1:0]   pending_r, pending_nxt_s;
  logic [FLOORS-1:0]   req_s, clr_s, here_s, up_s, dn_s, above_s, below_s;
  logic                moving_r, door_r, busy_r;
  logic                t_load_s, t_expired_s;
  logic [TW-1:0]       t_val_s;
  logic                ahead_s, behind_s;

  assign req_s    = hall_req | car_req;
  assign here_s   = ONE << floor_r;
  assign up_s     = here_s << 1;
  assign dn_s     = here_s >> 1;
  assign above_s  = pending_r & ~(up_s - ONE);
  assign below_s  = pending_r & (here_s - ONE);
  assign ahead_s  = (dir_r == DIR_UP) ? (|above_s) : (|below_s);
  assign behind_s = (dir_r == DIR_UP) ? (|below_s) : (|above_s);

  lift_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (t_load_s),
    .load_val (t_val_s),
    .expired  (t_expired_s)
  );

  // Next-state, floor, direction, timer control and stop clearing.
  always_comb begin
    state_nxt_s = state_r;
    floor_nxt_s = floor_r;
    dir_nxt_s   = dir_r;
    t_load_s    = 1'b0;
    t_val_s     = MOVE_LD;
    clr_s       = {FLOORS{1'b0}};
    case (state_r)
      ST_IDLE: begin
        if (|(pending_r & here_s)) begin
          state_nxt_s = ST_DOOR;
          t_load_s    = 1'b1;
          t_val_s     = DOOR_LD;
          clr_s       = here_s;
        end else if (ahead_s || behind_s) begin
          // Both sides pending: keep the committed direction.
          dir_nxt_s   = ahead_s ? dir_r : ~dir_r;
          state_nxt_s = (ahead_s ? dir_r : ~dir_r) ? ST_MOVE_UP : ST_MOVE_DN;
          t_load_s    = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_MOVE_UP: begin
        if (t_expired_s) begin
          floor_nxt_s = floor_r + FLOOR_W'(1);
          t_load_s    = 1'b1;
          if (|(pending_r & up_s)) begin
            state_nxt_s = ST_DOOR;
            t_val_s     = DOOR_LD;
            clr_s       = up_s;
          end else if (floor_r == FLOOR_W'(FLOORS - 2)) begin
            state_nxt_s = ST_IDLE;
          end else begin
            state_nxt_s = ST_MOVE_UP;
          end
        end else begin
          state_nxt_s = ST_MOVE_UP;
        end
      end
      ST_MOVE_DN: begin
        if (t_expired_s) begin
          floor_nxt_s = floor_r - FLOOR_W'(1);
          t_load_s    = 1'b1;
          if (|(pending_r & dn_s)) begin
            state_nxt_s = ST_DOOR;
            t_val_s     = DOOR_LD;
            clr_s       = dn_s;
          end else if (floor_r == FLOOR_W'(1)) begin
            state_nxt_s = ST_IDLE;
          end else begin
            state_nxt_s = ST_MOVE_DN;
          end
        end else begin
          state_nxt_s = ST_MOVE_DN;
        end
      end
      ST_DOOR: begin
        clr_s = here_s;
        if (door_hold || (|(req_s & here_s))) begin
          t_load_s = 1'b1;
          t_val_s  = DOOR_LD;
        end else if (t_expired_s) begin
          if (ahead_s || behind_s) begin
            dir_nxt_s   = ahead_s ? dir_r : ~dir_r;
            state_nxt_s = (ahead_s ? dir_r : ~dir_r) ? ST_MOVE_UP : ST_MOVE_DN;
            t_load_s    = 1'b1;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end else begin
          state_nxt_s = ST_DOOR;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
    pending_nxt_s = (pending_r | req_s) & ~clr_s;
  end

  // State, position, request mask and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      floor_r   <= {FLOOR_W{1'b0}};
      dir_r     <= DIR_UP;
      pending_r <= {FLOORS{1'b0}};
      moving_r  <= 1'b0;
      door_r    <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      floor_r   <= floor_nxt_s;
      dir_r     <= dir_nxt_s;
      pending_r <= pending_nxt_s;
      moving_r  <= (state_nxt_s == ST_MOVE_UP) || (state_nxt_s == ST_MOVE_DN);
      door_r    <= (state_nxt_s == ST_DOOR);
      busy_r    <= (state_nxt_s != ST_IDLE) || (|pending_nxt_s);
    end
  end

  assign floor_o     = floor_r;
  assign dir_up_o    = dir_r;
  assign moving_o    = moving_r;
  assign door_open_o = door_r;
  assign busy_o      = busy_r;
  assign pending_o   = pending_r;

endmodule

// File: tb/tb_lift_ctrl.sv
// Directed and random bench for lift_ctrl against a floor-by-floor SCAN model.
module tb_lift_ctrl;

  localparam int FLOORS   = 8;
  localparam int MOVE_CYC = 4;
  localparam int DOOR_CYC = 3;
  localparam int PH_IDLE  = 0;
  localparam int PH_MOVE  = 1;
  localparam int PH_DOOR  = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  hall_req = 8'h00;
  logic [7:0]  car_req = 8'h00;
  logic        door_hold = 1'b0;
  logic [2:0]  floor_o;
  logic        dir_up_o, moving_o, door_open_o, busy_o;
  logic [7:0]  pending_o;

  int checks = 0;
  int errors = 0;

  // Reference model: where the car is, what it is doing, what is owed.
  int       m_floor, m_phase, m_left;
  bit       m_dir;
  bit [7:0] m_pend;
  bit       door_prev;
  int       stops_q[$];

  lift_ctrl #(.FLOORS(FLOORS), .MOVE_CYC(MOVE_CYC), .DOOR_CYC(DOOR_CYC)) dut (
    .clk(clk), .rst_n(rst_n), .hall_req(hall_req), .car_req(car_req),
    .door_hold(door_hold), .floor_o(floor_o), .dir_up_o(dir_up_o),
    .moving_o(moving_o), .door_open_o(door_open_o), .busy_o(busy_o),
    .pending_o(pending_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit calls_toward(input bit [7:0] p, input int f, input bit up);
    for (int i = 0; i < FLOORS; i++) begin
      if (p[i] && (up ? (i > f) : (i < f))) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_floor = 0; m_dir = 1'b1; m_phase = PH_IDLE; m_left = 0; m_pend = 8'h00;
    door_prev = 1'b0;
  endtask

  task automatic depart(input bit [7:0] p);
    if (calls_toward(p, m_floor, m_dir)) begin
      m_phase = PH_MOVE; m_left = MOVE_CYC;
    end else if (calls_toward(p, m_floor, !m_dir)) begin
      m_dir = !m_dir; m_phase = PH_MOVE; m_left = MOVE_CYC;
    end else begin
      m_phase = PH_IDLE;
    end
  endtask

  task automatic model_step(input bit [7:0] h, input bit [7:0] c, input bit hold);
    bit [7:0] req, owed;
    bit       was_door;
    int       old_floor;
    req = h | c; owed = m_pend; was_door = (m_phase == PH_DOOR); old_floor = m_floor;
    if (m_phase == PH_IDLE) begin
      if (owed[m_floor]) begin
        m_phase = PH_DOOR; m_left = DOOR_CYC;
      end else begin
        depart(owed);
      end
    end else if (m_phase == PH_MOVE) begin
      m_left--;
      if (m_left == 0) begin
        m_floor = m_dir ? m_floor + 1 : m_floor - 1;
        if (owed[m_floor]) begin
          m_phase = PH_DOOR; m_left = DOOR_CYC;
        end else begin
          m_left = MOVE_CYC;
        end
      end
    end else begin
      if (hold || req[m_floor]) begin
        m_left = DOOR_CYC;
      end else begin
        m_left--;
        if (m_left == 0) depart(owed);
      end
    end
    m_pend = owed | req;
    if (was_door) m_pend[old_floor] = 1'b0;
    if (m_phase == PH_DOOR) m_pend[m_floor] = 1'b0;
  endtask

  task automatic compare_model();
    check("floor", 32'(floor_o), 32'(m_floor));
    check("dir", 32'(dir_up_o), 32'(m_dir));
    check("moving", 32'(moving_o), 32'(m_phase == PH_MOVE));
    check("door", 32'(door_open_o), 32'(m_phase == PH_DOOR));
    check("busy", 32'(busy_o), 32'((m_phase != PH_IDLE) || (m_pend != 8'h00)));
    check("pending", 32'(pending_o), 32'(m_pend));
  endtask

  task automatic cycle(input logic [7:0] h, input logic [7:0] c, input logic hold);
    hall_req = h; car_req = c; door_hold = hold;
    @(posedge clk);
    model_step(h, c, hold);
    #1;
    compare_model();
    if (door_open_o && !door_prev) stops_q.push_back(int'(floor_o));
    door_prev = door_open_o;
  endtask

  task automatic run_until_idle(input int budget, input string tag);
    int n = 0;
    while (busy_o && n < budget) begin
      cycle(8'h00, 8'h00, 1'b0);
      n++;
    end
    check(tag, 32'(busy_o), 32'd0);
  endtask

  task automatic wait_door(input int budget, input string tag);
    int n = 0;
    while (!door_open_o && n < budget) begin
      cycle(8'h00, 8'h00, 1'b0);
      n++;
    end
    check(tag, 32'(door_open_o), 32'd1);
  endtask

  initial begin
    int cnt, n;
    logic [7:0] h, c;

    // Reset and quiet idle period.
    model_reset();
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
    check("rst_floor", 32'(floor_o), 32'd0);
    check("rst_dir", 32'(dir_up_o), 32'd1);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_pending", 32'(pending_o), 32'd0);
    repeat (50) cycle(8'h00, 8'h00, 1'b0);
    check("idle50_floor", 32'(floor_o), 32'd0);
    check("idle50_busy", 32'(busy_o), 32'd0);

    // Car call to 5 from ground: latch then depart one edge later.
    stops_q.delete();
    cycle(8'h00, 8'h20, 1'b0);
    check("lat_pending", 32'(pending_o), 32'h20);
    check("lat_still_idle", 32'(moving_o), 32'd0);
    cycle(8'h00, 8'h00, 1'b0);
    check("lat_moving", 32'(moving_o), 32'd1);
    run_until_idle(200, "to5_timeout");
    check("to5_floor", 32'(floor_o), 32'd5);
    check("to5_stops", 32'(stops_q.size()), 32'd1);
    check("to5_pending", 32'(pending_o), 32'd0);

    // Up to 7 with calls for 6 and 2 placed during travel.
    stops_q.delete();
    cycle(8'h00, 8'h80, 1'b0);
    cycle(8'h04, 8'h40, 1'b0);
    run_until_idle(300, "sweep_timeout");
    check("sweep_nstops", 32'(stops_q.size()), 32'd3);
    if (stops_q.size() == 3) begin
      check("sweep_stop0", 32'(stops_q[0]), 32'd6);
      check("sweep_stop1", 32'(stops_q[1]), 32'd7);
      check("sweep_stop2", 32'(stops_q[2]), 32'd2);
    end
    check("sweep_floor", 32'(floor_o), 32'd2);
    check("sweep_dir", 32'(dir_up_o), 32'd0);

    // Door hold at 3 for 10 cycles: 13 open cycles in total.
    cycle(8'h00, 8'h08, 1'b0);
    wait_door(100, "hold_open_timeout");
    cnt = 1;
    for (int i = 0; i < 10; i++) begin
      cycle(8'h00, 8'h00, 1'b1);
      if (door_open_o) cnt++;
    end
    n = 0;
    while (door_open_o && n < 20) begin
      cycle(8'h00, 8'h00, 1'b0);
      if (door_open_o) cnt++;
      n++;
    end
    check("hold_open_cycles", 32'(cnt), 32'd13);

    // Hall call at the open floor: never latched, dwell restarts.
    cycle(8'h08, 8'h00, 1'b0);
    cycle(8'h00, 8'h00, 1'b0);
    check("recall_door", 32'(door_open_o), 32'd1);
    cnt = 1;
    cycle(8'h08, 8'h00, 1'b0);
    check("recall_no_pending", 32'(pending_o), 32'd0);
    if (door_open_o) cnt++;
    n = 0;
    while (door_open_o && n < 20) begin
      cycle(8'h00, 8'h00, 1'b0);
      if (door_open_o) cnt++;
      n++;
    end
    check("recall_open_cycles", 32'(cnt), 32'd4);

    // Go to 4 heading up, then calls at both ends (7 doubled hall+car).
    cycle(8'h00, 8'h10, 1'b0);
    run_until_idle(100, "to4_timeout");
    check("to4_dir", 32'(dir_up_o), 32'd1);
    stops_q.delete();
    cycle(8'h81, 8'h80, 1'b0);
    check("ends_pending", 32'(pending_o), 32'h81);
    run_until_idle(300, "ends_timeout");
    check("ends_nstops", 32'(stops_q.size()), 32'd2);
    if (stops_q.size() == 2) begin
      check("ends_stop0", 32'(stops_q[0]), 32'd7);
      check("ends_stop1", 32'(stops_q[1]), 32'd0);
    end

    // Random traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      h = 8'h00; c = 8'h00;
      if ($urandom_range(0, 11) == 0) h[$urandom_range(0, 7)] = 1'b1;
      if ($urandom_range(0, 11) == 0) c[$urandom_range(0, 7)] = 1'b1;
      cycle(h, c, ($urandom_range(0, 24) == 0));
    end
    run_until_idle(2000, "rand_timeout");

    // Reset while moving past floor 3.
    if (floor_o != 3'd0) begin
      cycle(8'h00, 8'h01, 1'b0);
      run_until_idle(300, "home_timeout");
    end
    cycle(8'h00, 8'h80, 1'b0);
    n = 0;
    while (!(floor_o == 3'd3 && moving_o) && n < 100) begin
      cycle(8'h00, 8'h00, 1'b0);
      n++;
    end
    check("midtravel_reached", 32'(floor_o == 3'd3 && moving_o), 32'd1);
    #3 rst_n = 1'b0;
    #1;
    check("abort_floor", 32'(floor_o), 32'd0);
    check("abort_dir", 32'(dir_up_o), 32'd1);
    check("abort_moving", 32'(moving_o), 32'd0);
    check("abort_door", 32'(door_open_o), 32'd0);
    check("abort_busy", 32'(busy_o), 32'd0);
    check("abort_pending", 32'(pending_o), 32'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (10) cycle(8'h00, 8'h00, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
